// File: rtl/idq_pkg.sv
// Shared constants for the instruction dispatch queue: RS class encodings and
// the position of the major opcode inside a packed instruction word.
package idq_pkg;

  localparam int NUM_RS    = 4;
  localparam int MAJOR_LSB = 72;
  localparam int MAJOR_W   = 4;

  localparam logic [NUM_RS-1:0] CLS_INT   = 4'b0001;
  localparam logic [NUM_RS-1:0] CLS_FPADD = 4'b0010;
  localparam logic [NUM_RS-1:0] CLS_FPMUL = 4'b0100;
  localparam logic [NUM_RS-1:0] CLS_LDST  = 4'b1000;

endpackage

// File: rtl/idq_classify.sv
// Maps a 4-bit major opcode to its one-hot reservation-station class.
// Purely combinational so the RS allocation logic can reuse it directly.
module idq_classify
  import idq_pkg::*;
(
  input  logic [MAJOR_W-1:0] opcode,
  output logic [NUM_RS-1:0]  rs_class
);

  always_comb begin
    rs_class = CLS_INT;
    unique case (opcode[3:1])
      3'b010:  rs_class = CLS_FPADD;
      3'b011:  rs_class = CLS_FPMUL;
      3'b100,
      3'b101:  rs_class = CLS_LDST;
      default: rs_class = CLS_INT;
    endcase
  end

endmodule

// File: rtl/instr_dispatch_queue.sv
// In-order instruction queue between decode and the RS/ROB. The head entry is
// classified by major opcode and dispatched only when its RS class and the ROB can take it.
module instr_dispatch_queue
  import idq_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int INSTR_W = 76,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [INSTR_W-1:0]         in_instr,
  output logic                       in_ready,
  input  logic                       stall_in,
  input  logic                       flush,
  input  logic [NUM_RS-1:0]          rs_avail,
  input  logic                       rob_avail,
  output logic                       disp_valid,
  output logic [INSTR_W-1:0]         disp_instr,
  output logic [NUM_RS-1:0]          disp_rs,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic [CNT_W-1:0]           stall_cycles
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [NUM_RS-1:0]  head_class;
  logic               enq;
  logic               deq;
  logic               head_blocked;

  idq_classify u_classify (
    .opcode   (mem[head][MAJOR_LSB +: MAJOR_W]),
    .rs_class (head_class)
  );

  assign empty    = (count == '0);
  assign full     = (count == FULL_OCC);
  assign in_ready = !full;

  // Head-of-line gating: only the head is ever considered, so younger entries wait behind it.
  assign disp_instr = mem[head];
  assign disp_rs    = empty ? '0 : head_class;
  assign disp_valid = !empty && !stall_in && !flush && rob_avail && |(rs_avail & head_class);

  assign enq          = in_valid && !full && !flush;
  assign deq          = disp_valid;
  assign head_blocked = !empty && !flush && !disp_valid;

  // Storage carries data only and is never reset.
  always_ff @(posedge clk) begin
    if (enq) mem[tail] <= in_instr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (deq) head <= head + PTR_W'(1);
      unique case ({enq, deq})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Survives flush on purpose: it measures lost dispatch bandwidth across the whole run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (head_blocked && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: doc/instr_dispatch_queue.md
# instr_dispatch_queue

Parametrised in-order instruction queue between decode and the reservation stations (RS) / reorder buffer (ROB). It buffers packed instruction words, classifies the head entry by major opcode into one of four RS classes, and dispatches strictly FIFO. The head blocks whenever its target RS or the ROB has no free slot, or a global stall is asserted. It adds flush, full/empty flags, an occupancy count and a head-of-line stall counter.

## Interface
- DEPTH, 8, queue entries; power of two, at least 2
- INSTR_W, 76, packed instruction width; at least 76; bits [75:72] are the major opcode
- CNT_W, 16, width of the stall-cycle counter
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- in_valid  in  1  decode offers in_instr this cycle
- in_instr  in  INSTR_W  {MajorOpcode, Source1, Source2, OffsetScale, Destination, MinorOpcode, HasAddress, Address, OffsetSub, pad}
- in_ready  out  1  queue can accept; equals !full
- stall_in  in  1  global dispatch hold
- flush  in  1  synchronous discard of all entries
- rs_avail  in  4  per-class RS has a free slot: [0] integer, [1] FP add, [2] FP mul, [3] load/store
- rob_avail  in  1  ROB has a free slot
- disp_valid  out  1  head dispatched this cycle
- disp_instr  out  INSTR_W  head entry
- disp_rs  out  4  one-hot target class of the head; zero when empty
- count  out  $clog2(DEPTH)+1  occupancy
- empty, full  out  1  occupancy flags
- stall_cycles  out  CNT_W  saturating count of blocked-head cycles

## Operation
- Enqueue fires when in_valid && in_ready. Write at tail; tail advances.
- in_ready does not depend on same-cycle dispatch. A full queue rejects input even if it dispatches that cycle.
- Classification of head opcode: 0x0–0x3 integer, 0x4–0x5 FP add, 0x6–0x7 FP mul, 0x8–0xB load/store, 0xC–0xF integer.
- disp_valid = !empty && !stall_in && !flush && rob_avail && rs_avail[class(head)].
- Dispatch fires whenever disp_valid is high; the consumer must accept. Head advances.
- No younger entry ever dispatches ahead of the head (head-of-line blocking).
- Enqueue and dispatch in the same cycle leave count unchanged.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count is a separate register. full = (count == DEPTH); empty = (count == 0).
- Flush clears head, tail and count the next edge and overrides enqueue and dispatch that cycle. stall_cycles is not cleared.
- stall_cycles increments in any cycle with !empty && !flush && !disp_valid, and saturates at 2^CNT_W-1.
- Storage array is not reset. disp_instr is don't-care while disp_valid is 0.

## Timing
- Reset values: in_ready 1, disp_valid 0, disp_rs 0, count 0, empty 1, full 0, stall_cycles 0. Pointers are 0.
- Reset may assert mid-operation; all contents are abandoned.
- Enqueue-to-dispatch latency is at least 1 cycle: an entry written at edge N is at the head from edge N onward and can dispatch in cycle N+1. There is no bypass through an empty queue.
- disp_valid, disp_instr and disp_rs are combinational from the head register, rs_avail, rob_avail, stall_in and flush. The RS/ROB must sample them at the next edge.
- Flags and count are registered and update at the edge after the event.

## Structure
- Package idq_pkg holds:
  - class encoding constants CLS_INT, CLS_FPADD, CLS_FPMUL, CLS_LDST and NUM_RS = 4
  - the opcode field position, MAJOR_LSB = 72
- Sub-module idq_classify: combinational, 4-bit major opcode in, 4-bit one-hot class out. Reused later by the RS allocation logic.

## Test plan
- Fill to full: DEPTH=8, rs_avail=0, 9 valid writes. Required: in_ready drops after the 8th, the 9th is not accepted, count=8, full=1, stall_cycles increments every cycle the head is blocked.
- Blocking order: enqueue opcodes 0x6 (FP mul) then 0x0 (integer), with rs_avail=4'b0001 and rob_avail=1. Required: no dispatch, because the integer entry waits behind the head. Then set rs_avail=4'b0101; required: FP mul dispatches with disp_rs=0100, integer dispatches the next cycle with disp_rs=0001.
- Wrap-around: 20 enqueue/dispatch pairs, all gates open. Required: outputs in exact input order, count stays at 1, pointers wrap twice.
- Simultaneous events: when full, dispatch and offer together; required: no enqueue, count goes to 7. Assert flush while in_valid=1 and the head is dispatchable; required: disp_valid=0, count 0 next cycle, stall_cycles unchanged.
- Reset and saturation: with CNT_W=4, block the head for 20 cycles; required: stall_cycles holds at 15. Then assert rst_n=0 asynchronously mid-cycle; required: all outputs take their reset values immediately.
